// File: rtl/ser_rx_fifo.sv
// Serial receiver (start/data/[parity]/stop framing) feeding a show-ahead receive FIFO.
// Optional feature macro: SER_RX_PARITY_EN compiles in the parity bit and its check.
module ser_rx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                               clk25,
    input  logic                               rst,
    input  logic                               serrx,
    output logic [DATA_BITS-1:0]               rd_data,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill,
    output logic                               frame_err,
    output logic                               overrun,
    output logic                               parity_err
);

    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [15:0]   HALF_LOAD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0]   FULL_LOAD = 16'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [FW-1:0] FILL_ONE  = FW'(1);
    localparam logic [FW-1:0] FILL_FULL = FW'(FIFO_DEPTH);

    if (CLK_DIV < 8 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("ser_rx_fifo: CLK_DIV out of range 8..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("ser_rx_fifo: DATA_BITS out of range 5..8");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ser_rx_fifo: FIFO_DEPTH must be a power of 2 in 2..256");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
        $error("ser_rx_fifo: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

`ifdef SER_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;

    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data, input logic par_bit);
        return ((^data) ^ par_bit) != 1'(PARITY_ODD);
    endfunction
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic [1:0]           sync_r;
    logic                 rxs_s;
    state_t               state_r, state_nxt;
    logic [15:0]          cnt_r, cnt_nxt;
    logic [IW-1:0]        idx_r, idx_nxt;
    logic [DATA_BITS-1:0] shift_r, shift_nxt;
    logic                 expired_s;
    logic                 push_s;
    logic                 frame_err_s, frame_err_r;
`ifdef SER_RX_PARITY_EN
    logic                 par_bad_r, par_bad_nxt;
    logic                 parity_err_s, parity_err_r;
`endif

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr_r, rd_ptr_nxt;
    logic [PW-1:0]        wr_ptr_r, wr_ptr_nxt;
    logic [FW-1:0]        fill_r, fill_nxt;
    logic                 full_s, pop_s, wr_en_s, overrun_s;
    logic                 rd_valid_r;
    logic [DATA_BITS-1:0] rd_data_r, head_nxt;
    logic                 overrun_r;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], serrx};
        end
    end

    assign rxs_s     = sync_r[1];
    assign expired_s = (cnt_r == 16'd0);

    // Receiver next-state: half-bit delay from the falling edge, then one bit period per sample
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        idx_nxt     = idx_r;
        shift_nxt   = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
`ifdef SER_RX_PARITY_EN
        par_bad_nxt  = par_bad_r;
        parity_err_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (!rxs_s) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START: begin
                if (!expired_s) begin
                    cnt_nxt = cnt_r - 16'd1;
                end else if (rxs_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DATA;
                    cnt_nxt   = FULL_LOAD;
                    idx_nxt   = {IW{1'b0}};
`ifdef SER_RX_PARITY_EN
                    par_bad_nxt = 1'b0;
`endif
                end
            end
            DATA: begin
                if (!expired_s) begin
                    cnt_nxt = cnt_r - 16'd1;
                end else begin
                    shift_nxt[idx_r] = rxs_s;
                    cnt_nxt          = FULL_LOAD;
                    if (idx_r == LAST_IDX) begin
                        state_nxt = AFTER_DATA;
                    end else begin
                        idx_nxt = idx_r + IDX_ONE;
                    end
                end
            end
`ifdef SER_RX_PARITY_EN
            PARITY: begin
                if (!expired_s) begin
                    cnt_nxt = cnt_r - 16'd1;
                end else begin
                    par_bad_nxt = parity_mismatch(shift_r, rxs_s);
                    cnt_nxt     = FULL_LOAD;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (!expired_s) begin
                    cnt_nxt = cnt_r - 16'd1;
                end else if (rxs_s) begin
                    state_nxt = IDLE;
`ifdef SER_RX_PARITY_EN
                    if (par_bad_r) begin
                        parity_err_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
`else
                    push_s = 1'b1;
`endif
                end else begin
                    frame_err_s = 1'b1;
                    state_nxt   = BREAK;
                end
            end
            BREAK: begin
                if (rxs_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BREAK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Receiver state register
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 16'd0;
            idx_r       <= {IW{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            frame_err_r <= 1'b0;
`ifdef SER_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            idx_r       <= idx_nxt;
            shift_r     <= shift_nxt;
            frame_err_r <= frame_err_s;
`ifdef SER_RX_PARITY_EN
            par_bad_r    <= par_bad_nxt;
            parity_err_r <= parity_err_s;
`endif
        end
    end

    // FIFO control: a pop frees the slot a full-FIFO push needs in the same cycle
    always_comb begin
        pop_s     = rd_valid_r & rd_ready;
        full_s    = (fill_r == FILL_FULL);
        wr_en_s   = push_s & (~full_s | pop_s);
        overrun_s = push_s & full_s & ~pop_s;
        rd_ptr_nxt = pop_s   ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        wr_ptr_nxt = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        case ({wr_en_s, pop_s})
            2'b10:   fill_nxt = fill_r + FILL_ONE;
            2'b01:   fill_nxt = fill_r - FILL_ONE;
            default: fill_nxt = fill_r;
        endcase
        if (wr_en_s && (wr_ptr_r == rd_ptr_nxt)) begin
            head_nxt = shift_r;
        end else begin
            head_nxt = mem_r[rd_ptr_nxt];
        end
    end

    // FIFO storage, deliberately left unreset
    always_ff @(posedge clk25) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, occupancy and registered head-of-queue outputs
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            fill_r     <= {FW{1'b0}};
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DATA_BITS{1'b0}};
            overrun_r  <= 1'b0;
        end else begin
            rd_ptr_r   <= rd_ptr_nxt;
            wr_ptr_r   <= wr_ptr_nxt;
            fill_r     <= fill_nxt;
            rd_valid_r <= (fill_nxt != {FW{1'b0}});
            rd_data_r  <= head_nxt;
            overrun_r  <= overrun_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign fill      = fill_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
`ifdef SER_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ser_rx_fifo.sv
// Scoreboard bench for ser_rx_fifo: expected characters are queued at stimulus time and
// checked by a monitor on every accepted pop; error pulses are counted and width-checked.
module tb_ser_rx_fifo;

    localparam int CLK_DIV    = 256;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int PARITY_ODD = 1;
`ifdef SER_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // edge (counted from the edge after which the start bit is driven) that takes the stop sample
    localparam int STOP_EDGE = 3 + CLK_DIV / 2 + (FRAME_BITS - 1) * CLK_DIV;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       serrx = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] fill;
    logic       frame_err, overrun, parity_err;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    ser_rx_fifo #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk25(clk25), .rst(rst), .serrx(serrx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .fill(fill),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk25 = ~clk25;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: compare every accepted character against the scoreboard and police pulse widths
    always @(negedge clk25) begin
        if (rd_valid && rd_ready) begin
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_data: got 0x%02h expected nothing queued", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    failures++;
                    $display("FAIL pop_data: got 0x%02h expected 0x%02h", rd_data, mon_exp);
                end
            end
        end
        if (frame_err) begin
            fe_cnt++;
            check("frame_err_width", int'(fe_prev), 0);
        end
        if (overrun) begin
            ov_cnt++;
            check("overrun_width", int'(ov_prev), 0);
        end
        if (parity_err) begin
            pe_cnt++;
            check("parity_err_width", int'(pe_prev), 0);
        end
        fe_prev = frame_err;
        ov_prev = overrun;
        pe_prev = parity_err;
    end

    task automatic send_bits(input logic [15:0] bits, input int n);
        @(posedge clk25);
        #1;
        for (int i = 0; i < n; i++) begin
            serrx = bits[i];
            repeat (CLK_DIV) @(posedge clk25);
            #1;
        end
        serrx = 1'b1;
    endtask

`ifdef SER_RX_PARITY_EN
    function automatic logic good_par(input logic [7:0] d);
        return 1'(PARITY_ODD) ^ (^d);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bits({5'b11111, stop_bit, good_par(d), d, 1'b0}, FRAME_BITS);
    endtask
`else
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bits({6'b111111, stop_bit, d, 1'b0}, FRAME_BITS);
    endtask
`endif

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk25);
        @(negedge clk25);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_fe, base_ov, base_pe, base_pops;

        // reset state
        wait_cycles(3);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_fill", int'(fill), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_parity_err", int'(parity_err), 0);
        @(posedge clk25);
        #1 rst = 1'b0;
        wait_cycles(4);

        // 0x41 with exact push latency
        exp_q.push_back(8'h41);
        fork
            send_frame(8'h41, 1'b1);
            begin
                @(posedge clk25);
                repeat (STOP_EDGE - 1) @(posedge clk25);
                @(negedge clk25);
                check("latency_before_stop", int'(rd_valid), 0);
                @(posedge clk25);
                @(negedge clk25);
                check("latency_after_stop", int'(rd_valid), 1);
                check("fill_after_0x41", int'(fill), 1);
            end
        join
        wait_cycles(4);
        check("head_0x41", int'(rd_data), 8'h41);
        @(posedge clk25);
        #1 rd_ready = 1'b1;
        wait_cycles(3);
        check("fill_after_pop", int'(fill), 0);
        check("pops_0x41", pops, 1);

        // 100-cycle glitch is rejected silently
        base_fe = fe_cnt; base_pe = pe_cnt; base_ov = ov_cnt;
        @(posedge clk25);
        #1 serrx = 1'b0;
        repeat (100) @(posedge clk25);
        #1 serrx = 1'b1;
        wait_cycles(2 * CLK_DIV);
        check("glitch_rd_valid", int'(rd_valid), 0);
        check("glitch_fill", int'(fill), 0);
        check("glitch_errs", (fe_cnt - base_fe) + (pe_cnt - base_pe) + (ov_cnt - base_ov), 0);

        // 0x55 with low stop bit and a 2-bit-time break, then 0x33
        base_fe = fe_cnt;
`ifdef SER_RX_PARITY_EN
        send_bits({3'b000, 1'b0, good_par(8'h55), 8'h55, 1'b0}, FRAME_BITS + 2);
`else
        send_bits({4'b0000, 1'b0, 8'h55, 1'b0}, FRAME_BITS + 2);
`endif
        wait_cycles(CLK_DIV);
        check("break_frame_err", fe_cnt - base_fe, 1);
        check("break_fill", int'(fill), 0);
        base_pops = pops;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        wait_cycles(4);
        check("after_break_pops", pops - base_pops, 1);
        check("after_break_fill", int'(fill), 0);

        // 17 frames into a FIFO nobody drains
        @(posedge clk25);
        #1 rd_ready = 1'b0;
        base_ov = ov_cnt;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        wait_cycles(4);
        check("fill_16", int'(fill), 16);
        check("no_overrun_yet", ov_cnt - base_ov, 0);
        send_frame(8'h10, 1'b1);
        wait_cycles(4);
        check("fill_still_16", int'(fill), 16);
        check("overrun_on_17", ov_cnt - base_ov, 1);
        check("head_0x00", int'(rd_data), 0);
        base_pops = pops;
        @(posedge clk25);
        #1 rd_ready = 1'b1;
        wait_cycles(20);
        check("drain_pops", pops - base_pops, 16);
        check("drain_fill", int'(fill), 0);

`ifdef SER_RX_PARITY_EN
        // odd parity: 0x01 with parity bit 1 is bad, with 0 is good
        base_pe = pe_cnt;
        send_bits({5'b11111, 1'b1, 1'b1, 8'h01, 1'b0}, FRAME_BITS);
        wait_cycles(4);
        check("parity_err_pulse", pe_cnt - base_pe, 1);
        check("parity_fill", int'(fill), 0);
        base_pops = pops;
        exp_q.push_back(8'h01);
        send_bits({5'b11111, 1'b1, 1'b0, 8'h01, 1'b0}, FRAME_BITS);
        wait_cycles(4);
        check("parity_ok_pops", pops - base_pops, 1);
`endif

        // reset during data bit 4 with three characters held
        @(posedge clk25);
        #1 rd_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        wait_cycles(4);
        check("pre_reset_fill", int'(fill), 3);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk25);
                repeat (5 * CLK_DIV + CLK_DIV / 2) @(posedge clk25);
                #1 rst = 1'b1;
                #1;
                check("mid_reset_fill", int'(fill), 0);
                check("mid_reset_rd_valid", int'(rd_valid), 0);
            end
        join
        @(posedge clk25);
        #1 rst = 1'b0;
        rd_ready = 1'b1;
        wait_cycles(CLK_DIV);
        check("post_reset_fill", int'(fill), 0);
        base_pops = pops;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        wait_cycles(4);
        check("post_reset_pops", pops - base_pops, 1);
        check("final_fill", int'(fill), 0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
